reduce_tree_pipe: RTL and testbench

- Pipelined, parametrised reduction tree that combines NUM_INPUT_DATA lanes of DATA_WIDTH-bit data into one word.
- Generalises the 1-bit OR tree:
  - multi-bit data
  - runtime-selectable operator (OR/AND/XOR/unsigned MAX)
  - per-lane valid masking with identity substitution
  - valid/ready backpressure through the whole pipeline
- Sits at the reduction end of the NoC, feeding the collection/output buffer.

---
 rtl/reduce_tree_pkg.sv | 49 ++++
 rtl/reduce_tree_node.sv | 60 ++++++
 rtl/reduce_tree_pipe.sv | 131 +++++++++++++
 tb/tb_reduce_tree_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_tree_pkg.sv
// ----------------------------------------------------------------------------
// reduce_tree_pkg
// Shared definitions for the pipelined reduction tree:
//   - operator select encodings (MODE_OR/AND/XOR/MAX)
//   - red_identity(mode): neutral element substituted for invalid lanes
//   - red_op(mode,a,b):   the two-input combine function
//   - num_node(n,level):  node count of a tree level, ceil(n / 2^level)
// The data helpers work on a RED_MAX_W-bit word; callers zero-extend their
// operands and truncate the result, so DATA_WIDTH must not exceed RED_MAX_W.
// Zero-extension is safe for all four operators, including the unsigned MAX.
// ----------------------------------------------------------------------------
package reduce_tree_pkg;

    localparam int unsigned RED_MODE_W = 2;
    localparam int unsigned RED_MAX_W  = 64;

    typedef logic [RED_MODE_W-1:0] red_mode_t;
    typedef logic [RED_MAX_W-1:0]  red_word_t;

    localparam red_mode_t MODE_OR  = 2'd0;
    localparam red_mode_t MODE_AND = 2'd1;
    localparam red_mode_t MODE_XOR = 2'd2;
    localparam red_mode_t MODE_MAX = 2'd3;

    // AND needs all ones; OR, XOR and unsigned MAX are neutral on zero.
    function automatic red_word_t red_identity(input red_mode_t mode);
        return (mode == MODE_AND) ? '1 : '0;
    endfunction

    function automatic red_word_t red_op(input red_mode_t mode,
                                         input red_word_t a,
                                         input red_word_t b);
        red_word_t res;
        res = '0;
        case (mode)
            MODE_OR:  res = a | b;
            MODE_AND: res = a & b;
            MODE_XOR: res = a ^ b;
            MODE_MAX: res = (a > b) ? a : b;
            default:  res = '0;
        endcase
        return res;
    endfunction

    function automatic int unsigned num_node(input int unsigned n, input int unsigned level);
        return (n + (32'd1 << level) - 32'd1) >> level;
    endfunction

endpackage

// File: rtl/reduce_tree_node.sv
// ----------------------------------------------------------------------------
// reduce_node
// One registered node of the reduction tree. Combines two identity-masked
// children with the beat's operator and sums their lane counts. With
// SINGLE_CHILD=1 the node only registers child a (odd-sized level tail).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   advance_i           shared pipeline enable; registers hold when low
//   mode_i              operator of the beat currently entering this node
//   a_data_i, a_cnt_i   first child value and contributing-lane count
//   b_data_i, b_cnt_i   second child (ignored when SINGLE_CHILD=1)
//   data_o, cnt_o       registered node value and count
// ----------------------------------------------------------------------------
module reduce_node
    import reduce_tree_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH    = 5,
    parameter bit          SINGLE_CHILD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance_i,
    input  red_mode_t             mode_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [CNT_WIDTH-1:0]  a_cnt_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic [CNT_WIDTH-1:0]  b_cnt_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_WIDTH-1:0]  cnt_o
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;

    if (SINGLE_CHILD) begin : g_pass
        assign data_d = a_data_i;
        assign cnt_d  = a_cnt_i;

        logic unused_b;
        assign unused_b = ^{b_data_i, b_cnt_i, mode_i};
    end else begin : g_comb
        assign data_d = DATA_WIDTH'(red_op(mode_i, RED_MAX_W'(a_data_i), RED_MAX_W'(b_data_i)));
        assign cnt_d  = a_cnt_i + b_cnt_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (advance_i) begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// ----------------------------------------------------------------------------
// reduce_tree_pipe
// Pipelined reduction tree: NUM_INPUT_DATA lanes of DATA_WIDTH bits are
// combined into one word over $clog2(NUM_INPUT_DATA) register stages, one per
// tree level, with a runtime operator (OR/AND/XOR/unsigned MAX), per-lane valid
// masking and valid/ready backpressure. All stages share one advance signal.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_valid      per-lane valid; a beat is offered when any bit is set
//   i_data_bus   lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_mode       operator for this beat: 0 OR, 1 AND, 2 XOR, 3 MAX
//   o_ready      a beat is accepted this cycle if offered
//   o_valid      result valid
//   o_data_bus   reduced result
//   o_lane_cnt   number of valid lanes that contributed to the result
//   i_ready      downstream accepts the result
//   i_en         block enable; freezes the pipeline when low
// ----------------------------------------------------------------------------
module reduce_tree_pipe
    import reduce_tree_pkg::*;
#(
    parameter int unsigned NUM_INPUT_DATA = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MODE_WIDTH     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_INPUT_DATA-1:0]            i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
    input  logic [MODE_WIDTH-1:0]                i_mode,
    output logic                                 o_ready,
    output logic                                 o_valid,
    output logic [DATA_WIDTH-1:0]                o_data_bus,
    output logic [$clog2(NUM_INPUT_DATA):0]      o_lane_cnt,
    input  logic                                 i_ready,
    input  logic                                 i_en
);

    localparam int unsigned NUM_LEVEL = $clog2(NUM_INPUT_DATA);
    localparam int unsigned CNT_WIDTH = NUM_LEVEL + 1;

    logic                  advance;
    logic                  entry_valid;
    red_mode_t             entry_mode;
    logic [DATA_WIDTH-1:0] entry_ident;

    // Level 0 is the masked input; levels 1..NUM_LEVEL are node registers.
    // Slots beyond a level's node count are tied to zero.
    logic [DATA_WIDTH-1:0] lvl_data [NUM_LEVEL+1][NUM_INPUT_DATA];
    logic [CNT_WIDTH-1:0]  lvl_cnt  [NUM_LEVEL+1][NUM_INPUT_DATA];

    // Beat-wide stage state: stage s holds the beat sitting in level s+1.
    logic [NUM_LEVEL-1:0]                 valid_q;
    logic [NUM_LEVEL-1:0][RED_MODE_W-1:0] mode_q;

    // Operator applied by the nodes that build level l+1.
    red_mode_t lvl_mode [NUM_LEVEL];

    assign entry_valid = |i_valid;
    assign entry_mode  = red_mode_t'(i_mode);
    assign entry_ident = DATA_WIDTH'(red_identity(entry_mode));

    // The last stage is only ever released by the downstream handshake.
    assign advance = i_en & (~o_valid | i_ready);
    assign o_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            mode_q  <= '0;
        end else if (advance) begin
            valid_q[0] <= entry_valid;
            mode_q[0]  <= entry_mode;
            for (int s = 1; s < int'(NUM_LEVEL); s++) begin
                valid_q[s] <= valid_q[s-1];
                mode_q[s]  <= mode_q[s-1];
            end
        end
    end

    assign lvl_mode[0] = entry_mode;
    for (genvar s = 1; s < NUM_LEVEL; s++) begin : g_mode_tap
        assign lvl_mode[s] = mode_q[s-1];
    end

    // The last stage's mode travels with the beat but nothing downstream needs it.
    logic unused_last_mode;
    assign unused_last_mode = ^mode_q[NUM_LEVEL-1];

    for (genvar k = 0; k < NUM_INPUT_DATA; k++) begin : g_entry
        assign lvl_data[0][k] = i_valid[k] ? i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : entry_ident;
        assign lvl_cnt[0][k]  = CNT_WIDTH'(i_valid[k]);
    end

    for (genvar l = 1; l <= NUM_LEVEL; l++) begin : g_level
        localparam int unsigned NIN  = num_node(NUM_INPUT_DATA, l - 1);
        localparam int unsigned NOUT = num_node(NUM_INPUT_DATA, l);

        for (genvar j = 0; j < NUM_INPUT_DATA; j++) begin : g_node
            if (j < NOUT) begin : g_live
                localparam bit          SINGLE = (2 * j + 1 >= NIN);
                localparam int unsigned B_IDX  = SINGLE ? 2 * j : 2 * j + 1;

                reduce_node #(
                    .DATA_WIDTH   (DATA_WIDTH),
                    .CNT_WIDTH    (CNT_WIDTH),
                    .SINGLE_CHILD (SINGLE)
                ) u_node (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .advance_i (advance),
                    .mode_i    (lvl_mode[l-1]),
                    .a_data_i  (lvl_data[l-1][2*j]),
                    .a_cnt_i   (lvl_cnt[l-1][2*j]),
                    .b_data_i  (lvl_data[l-1][B_IDX]),
                    .b_cnt_i   (lvl_cnt[l-1][B_IDX]),
                    .data_o    (lvl_data[l][j]),
                    .cnt_o     (lvl_cnt[l][j])
                );
            end else begin : g_pad
                assign lvl_data[l][j] = '0;
                assign lvl_cnt[l][j]  = '0;
            end
        end
    end

    assign o_valid    = valid_q[NUM_LEVEL-1];
    assign o_data_bus = lvl_data[NUM_LEVEL][0];
    assign o_lane_cnt = lvl_cnt[NUM_LEVEL][0];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// ----------------------------------------------------------------------------
// tb_reduce_tree_pipe
// Self-checking bench: a 16-lane instance driven by directed and random beats
// with a queue of expected results, and a 5-lane instance checked one beat at
// a time. Expected results come from a lane-by-lane accumulation model.
// ----------------------------------------------------------------------------
module tb_reduce_tree_pipe;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] cnt;
    } res_t;

    logic clk;
    logic rst_n;

    // 16-lane instance
    logic [15:0]  i_valid;
    logic [127:0] i_data_bus;
    logic [1:0]   i_mode;
    logic         o_ready;
    logic         o_valid;
    logic [7:0]   o_data_bus;
    logic [4:0]   o_lane_cnt;
    logic         i_ready;
    logic         i_en;

    // 5-lane instance
    logic [4:0]  v5;
    logic [39:0] d5;
    logic [1:0]  m5;
    logic        ordy5;
    logic        ov5;
    logic [7:0]  od5;
    logic [3:0]  oc5;

    int   n_checks;
    int   n_errors;
    res_t sb_q[$];
    logic hold_pend;
    res_t held;

    reduce_tree_pipe #(
        .NUM_INPUT_DATA (16),
        .DATA_WIDTH     (8),
        .MODE_WIDTH     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_mode     (i_mode),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_lane_cnt (o_lane_cnt),
        .i_ready    (i_ready),
        .i_en       (i_en)
    );

    reduce_tree_pipe #(
        .NUM_INPUT_DATA (5),
        .DATA_WIDTH     (8),
        .MODE_WIDTH     (2)
    ) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (v5),
        .i_data_bus (d5),
        .i_mode     (m5),
        .o_ready    (ordy5),
        .o_valid    (ov5),
        .o_data_bus (od5),
        .o_lane_cnt (oc5),
        .i_ready    (1'b1),
        .i_en       (1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reduction as a plain fold over the valid lanes.
    function automatic res_t ref_reduce(input logic [1:0] mode, input logic [15:0] valid,
                                        input logic [127:0] data, input int n);
        logic [7:0] acc;
        logic [7:0] d;
        logic [4:0] c;
        acc = (mode == 2'd1) ? 8'hFF : 8'h00;
        c   = '0;
        for (int k = 0; k < n; k++) begin
            if (valid[k]) begin
                d = data[k*8 +: 8];
                c = c + 5'd1;
                case (mode)
                    2'd0:    acc = acc | d;
                    2'd1:    acc = acc & d;
                    2'd2:    acc = acc ^ d;
                    default: if (d > acc) acc = d;
                endcase
            end
        end
        return {acc, c};
    endfunction

    // Called at a negedge with inputs already driven; scores the coming edge.
    task automatic step();
        res_t exp;
        #1;
        if (hold_pend) begin
            check_eq("hold_valid", 32'(o_valid), 32'd1);
            check_eq("hold_data", 32'(o_data_bus), 32'(held.data));
            check_eq("hold_cnt", 32'(o_lane_cnt), 32'(held.cnt));
        end
        check_eq("ready", 32'(o_ready), 32'(i_en & (~o_valid | i_ready)));
        if (o_valid && i_ready && i_en) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
                exp = sb_q.pop_front();
                check_eq("data", 32'(o_data_bus), 32'(exp.data));
                check_eq("cnt", 32'(o_lane_cnt), 32'(exp.cnt));
            end
        end
        hold_pend = o_valid && !(i_ready && i_en);
        held      = {o_data_bus, o_lane_cnt};
        if ((|i_valid) && o_ready) sb_q.push_back(ref_reduce(i_mode, i_valid, i_data_bus, 16));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle16();
        i_valid    = '0;
        i_data_bus = '0;
        i_mode     = '0;
    endtask

    task automatic drain();
        int guard;
        idle16();
        i_ready = 1'b1;
        i_en    = 1'b1;
        guard   = 0;
        while (sb_q.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // One beat through the 5-lane instance; checks latency and result.
    task automatic run5(input logic [1:0] mode, input logic [4:0] valid, input logic [39:0] data);
        res_t exp;
        int   lat;
        exp = ref_reduce(mode, {11'd0, valid}, {88'd0, data}, 5);
        v5  = valid;
        d5  = data;
        m5  = mode;
        @(posedge clk);
        @(negedge clk);
        v5  = '0;
        lat = 1;
        while (!ov5 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq("lat5", 32'(lat), 32'd3);
        check_eq("data5", 32'(od5), 32'(exp.data));
        check_eq("cnt5", 32'(oc5), 32'(exp.cnt));
    endtask

    initial begin
        int   lat;
        logic [4:0] rv;
        n_checks  = 0;
        n_errors  = 0;
        hold_pend = 1'b0;
        held      = '0;
        rst_n     = 1'b0;
        i_ready   = 1'b1;
        i_en      = 1'b1;
        idle16();
        v5 = '0;
        d5 = '0;
        m5 = '0;

        #2;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_data", 32'(o_data_bus), 32'd0);
        check_eq("rst_cnt", 32'(o_lane_cnt), 32'd0);
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // OR with one bit per lane position, all lanes valid
        i_valid = 16'hFFFF;
        i_mode  = 2'd0;
        for (int k = 0; k < 16; k++) i_data_bus[k*8 +: 8] = 8'(1 << (k % 8));
        step();
        idle16();
        lat = 1;
        while (!o_valid && lat < 20) begin
            step();
            lat++;
        end
        check_eq("lat_or", 32'(lat), 32'd4);
        check_eq("or_data", 32'(o_data_bus), 32'hFF);
        check_eq("or_cnt", 32'(o_lane_cnt), 32'd16);
        step();

        // AND with lane 3 invalid and zero
        i_valid = 16'hFFF7;
        i_mode  = 2'd1;
        for (int k = 0; k < 16; k++) i_data_bus[k*8 +: 8] = (k == 3) ? 8'h00 : 8'hF0;
        step();
        idle16();
        lat = 1;
        while (!o_valid && lat < 20) begin
            step();
            lat++;
        end
        check_eq("and_data", 32'(o_data_bus), 32'hF0);
        check_eq("and_cnt", 32'(o_lane_cnt), 32'd15);
        step();

        // Back-to-back XOR then MAX with downstream stalled
        i_valid    = 16'h00FF;
        i_mode     = 2'd2;
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
        step();
        i_valid    = 16'hF0F0;
        i_mode     = 2'd3;
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
        step();
        idle16();
        i_ready = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            step();
            lat++;
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("full_ready", 32'(o_ready), 32'd0);
            step();
        end
        i_ready = 1'b1;
        step();
        check_eq("b2b_second", 32'(o_valid), 32'd1);
        step();
        drain();

        // Stream with i_en dropped for two cycles
        for (int c = 0; c < 10; c++) begin
            i_valid    = 16'($urandom) | 16'h0001;
            i_mode     = 2'($urandom);
            i_data_bus = {$urandom, $urandom, $urandom, $urandom};
            i_en       = !(c == 5 || c == 6);
            step();
        end
        i_en = 1'b1;
        drain();

        // Reset while beats are in flight and a result is held at the output
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i_valid    = 16'hFFFF;
            i_mode     = 2'd0;
            i_data_bus = {4{32'h8040_2011}};
            step();
        end
        idle16();
        check_eq("pre_rst_valid", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
        check_eq("mid_rst_data", 32'(o_data_bus), 32'd0);
        check_eq("mid_rst_cnt", 32'(o_lane_cnt), 32'd0);
        sb_q.delete();
        hold_pend = 1'b0;
        i_ready   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) step();

        // Random traffic with random backpressure and enable
        for (int c = 0; c < 400; c++) begin
            i_valid    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            i_mode     = 2'($urandom);
            i_data_bus = {$urandom, $urandom, $urandom, $urandom};
            i_ready    = ($urandom_range(0, 3) != 0);
            i_en       = ($urandom_range(0, 7) != 0);
            step();
        end
        drain();

        // 5-lane instance: odd levels use the pass-through node
        run5(2'd3, 5'h1F, {8'd1, 8'd200, 8'd7, 8'd9, 8'd3});
        check_eq("max5_const", 32'(od5), 32'd200);
        for (int c = 0; c < 12; c++) begin
            rv = 5'($urandom);
            if (rv == 5'd0) rv = 5'd1;
            run5(2'(c % 4), rv, {$urandom, 8'($urandom)});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
